// File: rtl/pov_columns.sv
// Renders an 11-character string as 5x7 LED columns for a POV display, one sweep per index pulse.
// Text is double-buffered: strobes fill pend, and pend is copied into disp only when a sweep (re)starts.
module pov_columns #(
  parameter int COL_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] str,
  input  logic        complete,
  input  logic        change,
  input  logic        sync,
  output logic [6:0]  leds,
  output logic        active,
  output logic        frame_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [15:0] TC    = 16'(COL_CYCLES - 1);
  localparam logic [6:0]  BLANK = 7'h20;

  state_t      state;
  logic [6:0]  disp [11];
  logic [6:0]  pend [11];
  logic        pend_v;
  logic        s1, s2, s2_d, sync_edge;
  logic [15:0] presc;
  logic [2:0]  col;
  logic [3:0]  chr;

  logic        tc, last, swap;
  logic [2:0]  col_n;
  logic [3:0]  chr_n;
  logic [6:0]  code_n;

  // Five 7-bit columns, leftmost column in the top bits; bit 0 of each column is the top row.
  function automatic logic [34:0] glyph(input logic [6:0] code);
    logic [6:0] c;
    c = code;
    if (code >= 7'h61 && code <= 7'h7A)
      c = code - 7'h20;
    case (c)
      7'h2C: glyph = {7'h00, 7'h40, 7'h30, 7'h00, 7'h00};
      7'h30: glyph = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
      7'h31: glyph = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
      7'h32: glyph = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      7'h33: glyph = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
      7'h34: glyph = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      7'h35: glyph = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
      7'h36: glyph = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
      7'h37: glyph = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
      7'h38: glyph = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      7'h39: glyph = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
      7'h41: glyph = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
      7'h42: glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
      7'h43: glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
      7'h44: glyph = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
      7'h45: glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
      7'h46: glyph = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
      7'h47: glyph = {7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A};
      7'h48: glyph = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
      7'h49: glyph = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
      7'h4A: glyph = {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
      7'h4B: glyph = {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41};
      7'h4C: glyph = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
      7'h4D: glyph = {7'h7F, 7'h02, 7'h0C, 7'h02, 7'h7F};
      7'h4E: glyph = {7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F};
      7'h4F: glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
      7'h50: glyph = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
      7'h51: glyph = {7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E};
      7'h52: glyph = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
      7'h53: glyph = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
      7'h54: glyph = {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
      7'h55: glyph = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
      7'h56: glyph = {7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F};
      7'h57: glyph = {7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F};
      7'h58: glyph = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
      7'h59: glyph = {7'h07, 7'h08, 7'h70, 7'h08, 7'h07};
      7'h5A: glyph = {7'h61, 7'h51, 7'h49, 7'h45, 7'h43};
      7'h7E: glyph = {7'h7D, 7'h09, 7'h11, 7'h21, 7'h7D};
      default: glyph = 35'h0;
    endcase
  endfunction

  function automatic logic [6:0] col_bits(input logic [6:0] code, input logic [2:0] c);
    logic [34:0] g;
    g = glyph(code);
    case (c)
      3'd0:    col_bits = g[34:28];
      3'd1:    col_bits = g[27:21];
      3'd2:    col_bits = g[20:14];
      3'd3:    col_bits = g[13:7];
      3'd4:    col_bits = g[6:0];
      default: col_bits = 7'h00;
    endcase
  endfunction

  assign tc   = (presc == TC);
  assign last = (state == SWEEP) && tc && (col == 3'd5) && (chr == 4'd10);
  assign swap = sync_edge && pend_v;

  // Next column position; a sync edge forces the start of a new frame from any state.
  always_comb begin
    col_n = col;
    chr_n = chr;
    if (sync_edge) begin
      col_n = 3'd0;
      chr_n = 4'd0;
    end else if (tc) begin
      if (col == 3'd5) begin
        col_n = 3'd0;
        chr_n = (chr == 4'd10) ? 4'd0 : chr + 4'd1;
      end else begin
        col_n = col + 3'd1;
      end
    end
  end

  // On a swap the first column must come from the text being loaded, not the old frame.
  assign code_n = swap ? pend[chr_n] : disp[chr_n];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      leds       <= 7'h00;
      active     <= 1'b0;
      frame_done <= 1'b0;
      pend_v     <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s2_d       <= 1'b0;
      sync_edge  <= 1'b0;
      presc      <= 16'd0;
      col        <= 3'd0;
      chr        <= 4'd0;
      for (int k = 0; k < 11; k++) begin
        disp[k] <= BLANK;
        pend[k] <= BLANK;
      end
    end else begin
      s1         <= sync;
      s2         <= s1;
      s2_d       <= s2;
      sync_edge  <= s2 & ~s2_d;
      frame_done <= 1'b0;

      // A strobe coinciding with a swap lands after the copy, so it stays pending.
      if (complete) begin
        for (int k = 0; k < 11; k++)
          pend[k] <= str[76-7*k -: 7];
        pend_v <= 1'b1;
      end else if (change) begin
        for (int k = 0; k < 11; k++)
          pend[k] <= BLANK;
        pend_v <= 1'b1;
      end else if (swap) begin
        pend_v <= 1'b0;
      end

      if (swap) begin
        for (int k = 0; k < 11; k++)
          disp[k] <= pend[k];
      end

      if (sync_edge) begin
        state  <= SWEEP;
        active <= 1'b1;
        presc  <= 16'd0;
        col    <= 3'd0;
        chr    <= 4'd0;
        leds   <= col_bits(code_n, 3'd0);
      end else begin
        case (state)
          IDLE: begin
            leds   <= 7'h00;
            active <= 1'b0;
          end
          SWEEP: begin
            if (last) begin
              state      <= IDLE;
              active     <= 1'b0;
              leds       <= 7'h00;
              frame_done <= 1'b1;
              presc      <= 16'd0;
              col        <= 3'd0;
              chr        <= 4'd0;
            end else begin
              presc <= tc ? 16'd0 : presc + 16'd1;
              col   <= col_n;
              chr   <= chr_n;
              leds  <= col_bits(code_n, col_n);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pov_columns.sv
// Directed bench for pov_columns with COL_CYCLES=4: checks every column of each frame against hand-written glyphs.
module tb_pov_columns;

  localparam int C     = 4;
  localparam int FRAME = 66 * C;

  localparam logic [34:0] G_BL = 35'h0;
  localparam logic [34:0] G_H  = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
  localparam logic [34:0] G_1  = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
  localparam logic [34:0] G_CM = {7'h00, 7'h40, 7'h30, 7'h00, 7'h00};
  localparam logic [34:0] G_A  = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
  localparam logic [34:0] G_9  = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};

  logic        clk = 1'b0;
  logic        reset;
  logic [76:0] str;
  logic        complete, change, sync;
  logic [6:0]  leds;
  logic        active, frame_done;

  logic [34:0] fr [11];
  int checks = 0;
  int errors = 0;

  pov_columns #(.COL_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .str(str), .complete(complete), .change(change),
    .sync(sync), .leds(leds), .active(active), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [76:0] mk(input logic [6:0] c0, c1, c2, c3);
    logic [76:0] s;
    s = {11{7'h20}};
    s[76 -: 7] = c0;
    s[69 -: 7] = c1;
    s[62 -: 7] = c2;
    s[55 -: 7] = c3;
    return s;
  endfunction

  task automatic set_fr(input logic [34:0] g0, g1, g2, g3);
    for (int k = 0; k < 11; k++) fr[k] = G_BL;
    fr[0] = g0; fr[1] = g1; fr[2] = g2; fr[3] = g3;
  endtask

  function automatic logic [6:0] exp_leds(input int j);
    int c, k;
    logic [34:0] g;
    c = j / (6 * C);
    k = (j / C) % 6;
    if (k == 5 || c > 10) return 7'h00;
    g = fr[c];
    return g[34 - 7*k -: 7];
  endfunction

  task automatic strobe(input logic cmp, input logic chg, input logic [76:0] s);
    complete = cmp; change = chg; str = s;
    tick();
    complete = 1'b0; change = 1'b0;
  endtask

  // Starts a sweep and checks each cycle; optionally injects a strobe and/or a restarting sync edge.
  task automatic run_frame(input string tag, input int inj_at, input logic cmp,
                           input logic [76:0] inj_str, input int restart_at);
    int total, j, act_n, fd_n;
    total = (restart_at >= 0) ? restart_at + 4 + FRAME : FRAME;
    act_n = 0;
    fd_n  = 0;
    sync = 1'b1;
    repeat (4) tick();
    sync = 1'b0;
    for (int i = 0; i < total; i++) begin
      j = (restart_at >= 0 && i >= restart_at + 4) ? i - restart_at - 4 : i;
      if (leds !== exp_leds(j)) check($sformatf("%s_leds@%0d", tag, i), leds, exp_leds(j));
      else checks++;
      if (active) act_n++;
      if (frame_done) fd_n++;
      if (i == inj_at) begin
        complete = cmp; change = ~cmp; str = inj_str;
      end else begin
        complete = 1'b0; change = 1'b0;
      end
      if (i == restart_at) sync = 1'b1;
      if (i == restart_at + 3) sync = 1'b0;
      tick();
    end
    check({tag, "_active_cycles"}, act_n, total);
    check({tag, "_early_done"}, fd_n, 0);
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_end_active"}, active, 0);
    check({tag, "_end_leds"}, leds, 0);
    tick();
    check({tag, "_done_pulse"}, frame_done, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; str = '0; complete = 1'b0; change = 1'b0; sync = 1'b0;
    repeat (2) tick();
    check("rst_leds", leds, 0);
    check("rst_active", active, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_active", active, 0);

    set_fr(G_BL, G_BL, G_BL, G_BL);
    run_frame("blank", -1, 1'b0, '0, -1);

    strobe(1'b1, 1'b0, mk(7'h48, 7'h31, 7'h2C, 7'h20));
    set_fr(G_H, G_1, G_CM, G_BL);
    run_frame("h1comma", -1, 1'b0, '0, -1);

    run_frame("midA_old", 100, 1'b1, mk(7'h41, 7'h20, 7'h20, 7'h20), -1);
    set_fr(G_A, G_BL, G_BL, G_BL);
    run_frame("midA_new", -1, 1'b0, '0, -1);
    run_frame("midA_keep", -1, 1'b0, '0, -1);

    strobe(1'b1, 1'b1, mk(7'h39, 7'h20, 7'h20, 7'h20));
    set_fr(G_9, G_BL, G_BL, G_BL);
    run_frame("both9", -1, 1'b0, '0, -1);
    strobe(1'b0, 1'b1, '0);
    set_fr(G_BL, G_BL, G_BL, G_BL);
    run_frame("chg_blank", -1, 1'b0, '0, -1);

    strobe(1'b1, 1'b0, mk(7'h68, 7'h48, 7'h01, 7'h31));
    set_fr(G_H, G_H, G_BL, G_1);
    run_frame("restart", -1, 1'b0, '0, 20 * C);

    // Load more text mid-sweep, then reset at char 5: both buffers must come back blank.
    sync = 1'b1;
    repeat (4) tick();
    sync = 1'b0;
    for (int i = 0; i < 5 * 6 * C + 2; i++) begin
      complete = (i == 10);
      str = mk(7'h48, 7'h48, 7'h48, 7'h48);
      tick();
    end
    complete = 1'b0;
    check("pre_reset_active", active, 1);
    reset = 1'b1;
    tick();
    check("mid_reset_leds", leds, 0);
    check("mid_reset_active", active, 0);
    check("mid_reset_done", frame_done, 0);
    reset = 1'b0;
    repeat (3) tick();
    set_fr(G_BL, G_BL, G_BL, G_BL);
    run_frame("post_reset", -1, 1'b0, '0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pov_columns.md
# pov_columns

Downstream stage of the text-entry path: consumes the 77-bit, 11-character string and its `complete`/`change` strobes and renders it as LED column patterns for the persistence-of-vision display. A 5x7 font ROM turns each character into columns. Sweeps start on the rotation index sensor and advance at a fixed column rate. A shadow buffer keeps a frame from tearing when new text arrives mid-sweep.

## Interface
- `COL_CYCLES`, 2500: clk cycles each column is held; legal range 2..65535.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `string` in 77: char k (display position k, 0 = leftmost) in bits [76-7k : 70-7k]. Valid whenever `complete` is high.
- `complete` in 1: one-cycle strobe; the string is final.
- `change` in 1: one-cycle strobe; the string was cleared or edited, so the display blanks.
- `sync` in 1: index sensor, asynchronous to `clk`, active-high.
- `leds` out 7: current column; bit 0 = top row, 1 = LED on.
- `active` out 1: high while a sweep is in progress.
- `frame_done` out 1: one-cycle pulse when a sweep finishes normally.

## Operation
- **Buffers**
  - `disp` is 11x7 and is used by the current sweep.
  - `pend` is 11x7, with a flag `pend_v`.
  - Reset sets all entries of both to 7'h20 (blank) and clears `pend_v`.
- **Strobes**
  - `complete`: `pend`←`string`, `pend_v`←1.
  - `change` without `complete`: `pend`←all 7'h20, `pend_v`←1.
  - Both high in the same cycle: `complete` wins.
- **Sync conditioning**
  - `sync` passes through a 2-flop synchronizer, then a registered rising-edge detector.
  - `sync_edge` is a one-cycle internal pulse.
- **States**
  - IDLE: `leds`=0, `active`=0. On `sync_edge`: if `pend_v`, copy `pend`→`disp` and clear `pend_v`. Then clear all counters and go to SWEEP.
  - SWEEP: `active`=1. The prescaler counts 0..COL_CYCLES-1. At terminal count it advances the column counter 0..5, and at column wrap it advances the char counter 0..10.
  - When char 10, column 5 reaches terminal count: pulse `frame_done`, go to IDLE.
  - `sync_edge` during SWEEP restarts the sweep: counters cleared, pend→disp swap applied if `pend_v`, no `frame_done`.
- **Column content**
  - Columns 0..4 = glyph column of `disp[char]`. Column 5 = inter-character gap, `leds`=0.
  - Each frame is 66 columns, 66·COL_CYCLES cycles.
- **Font**
  - Glyphs exist for 7'h20 (blank), 7'h2C (comma), 7'h30–7'h39, 7'h41–7'h5A, and 7'h7E (Ñ).
  - 7'h61–7'h7A render as the uppercase glyphs. Every other code renders blank.
  - Glyph columns follow the team's standard 5x7 font. Anchor values:
    - 'H' = 7F,08,08,08,7F.
    - '1' = 00,42,7F,40,00.
    - ',' = 00,40,30,00,00.
- **Write protection:** `disp` is only ever written at a sweep (re)start.

## Timing
- All outputs are registered.
- Reset values: `leds`=0, `active`=0, `frame_done`=0, state IDLE, counters 0.
- A `sync` rising edge first sampled at clk edge N gives `sync_edge` high in the cycle after edge N+2.
- At edge N+3: state=SWEEP, `active`=1, `leds`=glyph column 0 of `disp[0]`.
- Each column is held exactly COL_CYCLES cycles.
- On the final column, `leds`=0 and `active`=0 from the edge at which the column's COL_CYCLES expire. `frame_done` is high for exactly that one cycle.
- `sync` held high does not retrigger; only 0→1 transitions do.
- Reset mid-sweep:
  - Next edge gives IDLE, `leds`=0, and both buffers blank.
  - No `frame_done`.
- **Strobe timing**
  - A strobe in the same cycle as an IDLE `sync_edge` is not seen by that swap; it remains pending.
  - A strobe during a sweep never alters the running frame.

## Test plan
- Reset, then `sync` pulse with no text → `active`=1 for 66·COL_CYCLES cycles, `leds`=0 throughout, one `frame_done`, back to IDLE.
- COL_CYCLES=4, `complete` with chars "H1," + 8 blanks, then `sync` → from edge N+3: `leds` 7F×4, 08×12, 7F×4, 00×4, then 00,42,7F,40,00 each ×4, 00×4, then 00,40,30,00,00 each ×4, then zeros; `frame_done` after 264 cycles.
- `complete` with "A" mid-sweep → current frame unchanged; next `sync` shows 'A'; `pend_v` cleared.
- `complete` and `change` in the same cycle with "9" → next frame shows '9', not blank. Later `change` alone → next frame blank.
- Second `sync` edge at column 20 → restart at char 0 column 0 three edges later, no `frame_done` for the aborted frame. Lowercase 'h' renders identical to 'H'; code 7'h01 renders blank.
- `reset` asserted at char 5 → `leds`=0 and `active`=0 next edge. Following sweep is all blank even though text was loaded before.
